// File: rtl/rr_arbiter_3_if.sv
// ============================================================================
// Module   : rr_arbiter_3_if
// Purpose  : Request/grant bundle between three requesters and rr_arbiter_3.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface rr_arbiter_3_if;
    logic [2:0] req_i;
    logic [2:0] gnt_o;
    logic [1:0] gnt_id_o;
    logic       busy_o;
    logic       timeout_o;

    modport master (
        output req_i,
        input  gnt_o,
        input  gnt_id_o,
        input  busy_o,
        input  timeout_o
    );

    modport slave (
        input  req_i,
        output gnt_o,
        output gnt_id_o,
        output busy_o,
        output timeout_o
    );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter_3.sv
// ============================================================================
// Module   : rr_arbiter_3
// Purpose  : Three-way round-robin arbiter with hold limit and turnaround cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter_3 #(
    parameter logic [2:0] REQ_POLARITY_MASK = 3'b000,
    parameter logic [7:0] MAX_HOLD          = 8'd16
) (
    input  wire logic       sysclk,
    input  wire logic       sys_rst_n,
    rr_arbiter_3_if.slave   bus
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_GRANT     = 2'd1;
    localparam logic [1:0] c_RELEASE   = 2'd2;
    localparam logic [1:0] c_NO_ID     = 2'd3;
    localparam logic [7:0] c_HOLD_LAST = MAX_HOLD - 8'd1;

    logic [1:0] r_state;
    logic [2:0] r_gnt;
    logic [1:0] r_gnt_id;
    logic       r_busy;
    logic       r_timeout;
    logic [7:0] r_cnt;
    logic [1:0] r_last;

    logic [2:0] w_eff;
    logic       w_any;
    logic       w_found;
    logic [1:0] w_start;
    logic [2:0] w_idx;
    logic [1:0] w_win;
    logic       w_hold_req;

    logic [1:0] w_state_nxt;
    logic [2:0] w_gnt_nxt;
    logic [1:0] w_id_nxt;
    logic       w_timeout_nxt;
    logic [7:0] w_cnt_nxt;
    logic [1:0] w_last_nxt;

    assign w_eff      = bus.req_i ^ REQ_POLARITY_MASK;
    assign w_any      = |w_eff;
    assign w_hold_req = |(w_eff & r_gnt);

    // Round-robin search starting just after the previous winner.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_idx   = 3'd0;
        w_start = (r_last >= 2'd2) ? 2'd0 : r_last + 2'd1;
        for (int k = 0; k < 3; k++) begin
            w_idx = {1'b0, w_start} + 3'(k);
            if (w_idx > 3'd2) begin
                w_idx = w_idx - 3'd3;
            end
            if (!w_found && w_eff[w_idx[1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_id_nxt      = r_gnt_id;
        w_timeout_nxt = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_last_nxt    = r_last;
        case (r_state)
            c_IDLE, c_RELEASE: begin
                if (w_any) begin
                    w_state_nxt = c_GRANT;
                    w_gnt_nxt   = 3'b001 << w_win;
                    w_id_nxt    = w_win;
                    w_cnt_nxt   = 8'd0;
                    w_last_nxt  = w_win;
                end else begin
                    w_state_nxt = c_IDLE;
                    w_gnt_nxt   = 3'b000;
                    w_id_nxt    = c_NO_ID;
                end
            end
            c_GRANT: begin
                // A dropped request wins over an expiring hold: no timeout pulse.
                if (!w_hold_req) begin
                    w_state_nxt = c_RELEASE;
                    w_gnt_nxt   = 3'b000;
                    w_id_nxt    = c_NO_ID;
                end else if ((MAX_HOLD != 8'd0) && (r_cnt == c_HOLD_LAST)) begin
                    w_state_nxt   = c_RELEASE;
                    w_gnt_nxt     = 3'b000;
                    w_id_nxt      = c_NO_ID;
                    w_timeout_nxt = 1'b1;
                end else if (r_cnt != 8'hFF) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_gnt_nxt   = 3'b000;
                w_id_nxt    = c_NO_ID;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= c_IDLE;
            r_gnt     <= 3'b000;
            r_gnt_id  <= c_NO_ID;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= 8'd0;
            r_last    <= 2'd2;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_id_nxt;
            r_busy    <= (w_state_nxt == c_GRANT);
            r_timeout <= w_timeout_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last    <= w_last_nxt;
        end
    end

    assign bus.gnt_o     = r_gnt;
    assign bus.gnt_id_o  = r_gnt_id;
    assign bus.busy_o    = r_busy;
    assign bus.timeout_o = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_3.sv
// ============================================================================
// Module   : tb_rr_arbiter_3
// Purpose  : Directed self-checking bench for rr_arbiter_3 in three configurations.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_3;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    rr_arbiter_3_if bus_a ();
    rr_arbiter_3_if bus_b ();
    rr_arbiter_3_if bus_c ();

    rr_arbiter_3 #(.REQ_POLARITY_MASK(3'b000), .MAX_HOLD(8'd4)) u_dut_a (
        .sysclk(clk), .sys_rst_n(rst_n), .bus(bus_a.slave)
    );
    rr_arbiter_3 #(.REQ_POLARITY_MASK(3'b101), .MAX_HOLD(8'd16)) u_dut_b (
        .sysclk(clk), .sys_rst_n(rst_n), .bus(bus_b.slave)
    );
    rr_arbiter_3 #(.REQ_POLARITY_MASK(3'b000), .MAX_HOLD(8'd0)) u_dut_c (
        .sysclk(clk), .sys_rst_n(rst_n), .bus(bus_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset, check reset outputs, then release just after an edge.
    task automatic do_reset();
        rst_n       = 1'b0;
        bus_a.req_i = 3'b000;
        bus_b.req_i = 3'b101;
        bus_c.req_i = 3'b000;
        tick();
        tick();
        chk("rst_gnt",  {29'd0, bus_a.gnt_o},     32'd0);
        chk("rst_id",   {30'd0, bus_a.gnt_id_o},  32'd3);
        chk("rst_busy", {31'd0, bus_a.busy_o},    32'd0);
        chk("rst_to",   {31'd0, bus_a.timeout_o}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // All three requesting, hold limit 4: order 0,1,2,0 with timeout turnarounds.
        do_reset();
        bus_a.req_i = 3'b111;
        begin
            logic [1:0] order [4];
            order = '{2'd0, 2'd1, 2'd2, 2'd0};
            for (int g = 0; g < 4; g++) begin
                for (int c = 0; c < 4; c++) begin
                    tick();
                    chk("rr_gnt",  {29'd0, bus_a.gnt_o},     32'd1 << order[g]);
                    chk("rr_id",   {30'd0, bus_a.gnt_id_o},  {30'd0, order[g]});
                    chk("rr_busy", {31'd0, bus_a.busy_o},    32'd1);
                    chk("rr_to0",  {31'd0, bus_a.timeout_o}, 32'd0);
                end
                tick();
                chk("rr_rel_gnt", {29'd0, bus_a.gnt_o},     32'd0);
                chk("rr_rel_id",  {30'd0, bus_a.gnt_id_o},  32'd3);
                chk("rr_rel_to",  {31'd0, bus_a.timeout_o}, 32'd1);
            end
        end

        // Three-cycle pulse on requester 1 from IDLE.
        do_reset();
        tick();
        chk("idle_gnt", {29'd0, bus_a.gnt_o}, 32'd0);
        bus_a.req_i = 3'b010;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("pulse_gnt", {29'd0, bus_a.gnt_o},     32'd2);
            chk("pulse_to",  {31'd0, bus_a.timeout_o}, 32'd0);
        end
        bus_a.req_i = 3'b000;
        tick();
        chk("pulse_rel_gnt",  {29'd0, bus_a.gnt_o},     32'd0);
        chk("pulse_rel_busy", {31'd0, bus_a.busy_o},    32'd0);
        chk("pulse_rel_to",   {31'd0, bus_a.timeout_o}, 32'd0);
        tick();
        chk("pulse_idle_gnt", {29'd0, bus_a.gnt_o},     32'd0);
        chk("pulse_idle_id",  {30'd0, bus_a.gnt_id_o},  32'd3);
        chk("pulse_idle_to",  {31'd0, bus_a.timeout_o}, 32'd0);

        // Polarity mask 101: raw 101 means nobody, raw 100 means requester 0.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("pol_idle_gnt",  {29'd0, bus_b.gnt_o},  32'd0);
            chk("pol_idle_busy", {31'd0, bus_b.busy_o}, 32'd0);
        end
        bus_b.req_i = 3'b100;
        tick();
        chk("pol_gnt", {29'd0, bus_b.gnt_o},    32'd1);
        chk("pol_id",  {30'd0, bus_b.gnt_id_o}, 32'd0);

        // Holder 2 drops exactly when the hold limit would fire: no timeout.
        do_reset();
        bus_a.req_i = 3'b100;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("drop_gnt", {29'd0, bus_a.gnt_o}, 32'd4);
        end
        bus_a.req_i = 3'b000;
        tick();
        chk("drop_rel_gnt", {29'd0, bus_a.gnt_o},     32'd0);
        chk("drop_rel_to",  {31'd0, bus_a.timeout_o}, 32'd0);
        chk("drop_rel_bsy", {31'd0, bus_a.busy_o},    32'd0);

        // Sole requester revoked by timeout is granted again after turnaround.
        do_reset();
        bus_a.req_i = 3'b001;
        for (int c = 0; c < 4; c++) tick();
        chk("sole_gnt", {29'd0, bus_a.gnt_o}, 32'd1);
        tick();
        chk("sole_to",  {31'd0, bus_a.timeout_o}, 32'd1);
        chk("sole_rel", {29'd0, bus_a.gnt_o},     32'd0);
        tick();
        chk("sole_regnt", {29'd0, bus_a.gnt_o},     32'd1);
        chk("sole_to_end", {31'd0, bus_a.timeout_o}, 32'd0);

        // Asynchronous reset mid-grant, then eff=110 picks requester 1.
        do_reset();
        bus_a.req_i = 3'b111;
        tick();
        tick();
        chk("ar_pre_gnt", {29'd0, bus_a.gnt_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt",  {29'd0, bus_a.gnt_o},    32'd0);
        chk("ar_id",   {30'd0, bus_a.gnt_id_o}, 32'd3);
        chk("ar_busy", {31'd0, bus_a.busy_o},   32'd0);
        bus_a.req_i = 3'b110;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_post_gnt", {29'd0, bus_a.gnt_o},    32'd2);
        chk("ar_post_id",  {30'd0, bus_a.gnt_id_o}, 32'd1);

        // Unlimited hold: grant persists well past counter saturation.
        do_reset();
        bus_c.req_i = 3'b001;
        for (int c = 0; c < 300; c++) begin
            tick();
            chk("unl_gnt", {29'd0, bus_c.gnt_o},     32'd1);
            chk("unl_to",  {31'd0, bus_c.timeout_o}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rr_arbiter_3.md
RR_ARBITER_3 -- requirements
Module: rr_arbiter_3

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset; the clock port is sysclk and the reset port is sys_rst_n.
REQ-002 Parameter REQ_POLARITY_MASK, default 3'b000, SHALL set per-requester request polarity: bit n = 1 means req_i[n] is active-low.
REQ-003 Parameter MAX_HOLD, default 8'd16, SHALL set the maximum number of cycles one grant may be held; 0 means unlimited.
REQ-004 Port sysclk  in  1  system clock, all state updates on the rising edge.
REQ-005 Port sys_rst_n  in  1  asynchronous active-low reset.
REQ-006 Port req_i  in  3  raw request lines, one per requester, polarity per REQ_POLARITY_MASK.
REQ-007 Port gnt_o  out  3  one-hot grant, registered.
REQ-008 Port gnt_id_o  out  2  index of the current grant holder, 2'd3 when no grant is held, registered.
REQ-009 Port busy_o  out  1  high while the FSM is in the GRANT state, registered.
REQ-010 Port timeout_o  out  1  single-cycle pulse when a grant is revoked by MAX_HOLD, registered.

Function
REQ-011 The effective request SHALL be eff[n] = req_i[n] XOR REQ_POLARITY_MASK[n]; all decisions SHALL use eff only.
REQ-012 The FSM SHALL have exactly three states, IDLE, GRANT and RELEASE, encoded in 2 bits; the unused code SHALL return to IDLE on the next clock.
REQ-013 IDLE: if any eff bit is set, the FSM SHALL go to GRANT and assert the winner's gnt_o bit on the next edge, giving a 1-cycle latency from request to grant; otherwise it SHALL stay in IDLE.
REQ-014 The winner SHALL be the first set eff bit searched from (last+1) mod 3 upward with wrap-around, where last is the 2-bit index of the previous winner.
REQ-015 last SHALL be updated to the winner index on every IDLE->GRANT and RELEASE->GRANT transition, and only then.
REQ-016 GRANT: gnt_o SHALL stay constant, and the 8-bit hold counter SHALL increment once per cycle, saturating at 8'hFF.
REQ-017 GRANT: if the holder's eff bit is 0, the FSM SHALL go to RELEASE; gnt_o SHALL be 0 and gnt_id_o SHALL be 2'd3 from the next edge.
REQ-018 GRANT: if MAX_HOLD != 0, the holder's eff bit is still 1 and the counter equals MAX_HOLD-1, the FSM SHALL go to RELEASE and pulse timeout_o for exactly that next cycle.
REQ-019 If the holder's request drops in the same cycle as the timeout condition, the drop SHALL take precedence and timeout_o SHALL stay 0.
REQ-020 RELEASE SHALL last exactly one cycle with gnt_o = 0 (bus turnaround); from RELEASE the FSM SHALL apply the REQ-013/014 arbitration and go to GRANT if any eff bit is set, else to IDLE.
REQ-021 The hold counter SHALL clear to 0 on every entry into GRANT.
REQ-022 A requester revoked by timeout that keeps requesting SHALL have the lowest priority at the next arbitration; if it is the sole requester, it SHALL be granted again.
REQ-023 gnt_o SHALL never have more than one bit set, and SHALL be 0 in IDLE and RELEASE.
REQ-024 Request changes by non-holders during GRANT SHALL NOT affect gnt_o until the next arbitration.

Reset
REQ-025 While sys_rst_n = 0 the block SHALL asynchronously force state = IDLE, gnt_o = 3'b000, gnt_id_o = 2'd3, busy_o = 0, timeout_o = 0, counter = 0 and last = 2'd2, so that requester 0 wins first.
REQ-026 Reset asserted mid-grant SHALL drop gnt_o in the same cycle without passing through RELEASE.
REQ-027 After reset deasserts, the first arbitration SHALL occur on the first rising edge with sys_rst_n = 1.

Verification
REQ-028 Reset, then eff = 3'b111 held constantly with MAX_HOLD = 4 -> grant order 0,1,2,0; each grant lasts 4 cycles; each is followed by 1 RELEASE cycle with timeout_o = 1.
REQ-029 eff[1] pulses for 3 cycles starting in IDLE -> gnt_o = 3'b010 from cycle +1 to +3, RELEASE at +4, then IDLE; timeout_o stays 0.
REQ-030 REQ_POLARITY_MASK = 3'b101, req_i = 3'b101 (nobody requesting) -> stays IDLE; then req_i = 3'b100 -> gnt_o = 3'b001 one cycle later.
REQ-031 MAX_HOLD = 4, holder 2 drops its request on the same cycle the counter reaches 3 -> RELEASE with timeout_o = 0.
REQ-032 sys_rst_n pulled low asynchronously mid-GRANT -> gnt_o = 0, gnt_id_o = 3 immediately; after release with eff = 3'b110, the winner is 1.
REQ-033 MAX_HOLD = 0, eff[0] held 300 cycles -> grant held throughout, counter saturates at 8'hFF, no timeout_o.
